// File: rtl/msg_stream_arbiter_if.sv
// Bus between NREQ message sources, the round-robin arbiter and the shared
// message datapath. Sources and the datapath form the master side; the arbiter is the slave.
interface msg_stream_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int MSG_W = 5
);
  // Handshake: a source raises req[i] and holds it until it sees ack[i] for
  // one cycle. The arbiter latches msg_in[i] when it grants. It then pulses
  // dp_start for one cycle and treats dp_done (pulse or level) as completion
  // only while it is waiting. At the end it pulses ack[owner] once, with
  // timeout_err if service was forced.
  logic [NREQ-1:0]       req;
  logic [NREQ*MSG_W-1:0] msg_in;
  logic [NREQ-1:0]       ack;
  logic                  dp_start;
  logic [MSG_W-1:0]      dp_msg;
  logic                  dp_done;
  logic                  busy;
  logic [2:0]            owner;
  logic                  timeout_err;

  modport master (
    output req, msg_in, dp_done,
    input  ack, dp_start, dp_msg, busy, owner, timeout_err
  );

  modport slave (
    input  req, msg_in, dp_done,
    output ack, dp_start, dp_msg, busy, owner, timeout_err
  );
endinterface

// File: rtl/msg_stream_arbiter.sv
// Round-robin arbiter and sequencer sharing one message datapath among NREQ
// sources: grant, start pulse, wait for done or timeout, acknowledge, rotate.
module msg_stream_arbiter #(
  parameter int NREQ    = 4,
  parameter int MSG_W   = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  msg_stream_arbiter_if.slave   bus,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       owner_q;
  logic [MSG_W-1:0] dp_msg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [NREQ-1:0]  ack_q;
  logic             dp_start_q;
  logic             busy_q;
  logic             timeout_err_q;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [3:0]        wsum;
  logic [2:0]        winner;
  logic              found;
  logic [MSG_W-1:0]  msg_sel;

  // Rotate requests so bit 0 is the current priority holder; the lowest set
  // bit of the rotated vector is the winner, mapped back modulo NREQ.
  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = NREQ'(req_dbl >> ptr_q);
    found   = 1'b0;
    winner  = '0;
    wsum    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        wsum  = 4'(ptr_q) + 4'(k);
        if (wsum >= 4'(NREQ)) begin
          wsum = wsum - 4'(NREQ);
        end
        winner = wsum[2:0];
      end
    end
    msg_sel = MSG_W'(bus.msg_in >> (int'(winner) * MSG_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      dp_msg_q      <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      ack_q         <= '0;
      dp_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q         <= '0;
      dp_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (found) begin
            owner_q    <= winner;
            dp_msg_q   <= msg_sel;
            cnt_q      <= '0;
            state_q    <= ST_GRANT;
            dp_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_GRANT: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Completion takes precedence over a timeout landing in the same cycle.
          if (bus.dp_done) begin
            state_q <= ST_RELEASE;
            ack_q   <= NREQ'(1) << owner_q;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= ST_RELEASE;
            err_q         <= 1'b1;
            ack_q         <= NREQ'(1) << owner_q;
            timeout_err_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          err_q   <= 1'b0;
          ptr_q   <= (owner_q == IDX_LAST) ? 3'd0 : owner_q + 3'd1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.dp_start    = dp_start_q;
  assign bus.dp_msg      = dp_msg_q;
  assign bus.busy        = busy_q;
  assign bus.owner       = owner_q;
  assign bus.timeout_err = timeout_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// Directed, table-driven bench for msg_stream_arbiter (NREQ=4, MSG_W=5, TIMEOUT=8).
module tb_msg_stream_arbiter;

  localparam int NREQ    = 4;
  localparam int MSG_W   = 5;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 255;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  msg_stream_arbiter_if #(.NREQ(NREQ), .MSG_W(MSG_W)) bus ();

  msg_stream_arbiter #(.NREQ(NREQ), .MSG_W(MSG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0]  req;
    logic [19:0] msg_in;
    int          done_dly;
    logic        drop;
    logic [2:0]  exp_owner;
    logic [4:0]  exp_msg;
    logic [3:0]  exp_ack;
    logic        exp_terr;
  } vec_t;

  vec_t tv[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(input int max_cycles, output bit seen, output bit ack_seen);
    seen     = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.ack != '0) ack_seen = 1'b1;
      if (bus.dp_start) seen = 1'b1;
    end
  endtask

  initial begin
    bit   seen;
    bit   ack_seen;
    bit   early;
    int   exp_o;

    n_vec = 0;
    n_err = 0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.msg_in  = '0;
    bus.dp_done = 1'b0;

    //            req      msg_in {m3,m2,m1,m0}               dly    drop owner msg    ack      terr
    tv[0] = '{4'b0100, {5'h00, 5'h15, 5'h00, 5'h00}, 6,     1'b0, 3'd2, 5'h15, 4'b0100, 1'b0};
    tv[1] = '{4'b0101, {5'h03, 5'h0A, 5'h1F, 5'h07}, 3,     1'b0, 3'd0, 5'h07, 4'b0001, 1'b0};
    tv[2] = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'h11}, NEVER, 1'b0, 3'd0, 5'h11, 4'b0001, 1'b1};
    tv[3] = '{4'b0001, {5'h1E, 5'h00, 5'h00, 5'h01}, 8,     1'b0, 3'd0, 5'h01, 4'b0001, 1'b0};
    tv[4] = '{4'b1001, {5'h1C, 5'h02, 5'h04, 5'h08}, 1,     1'b0, 3'd3, 5'h1C, 4'b1000, 1'b0};
    tv[5] = '{4'b1010, {5'h13, 5'h00, 5'h0D, 5'h00}, 2,     1'b1, 3'd1, 5'h0D, 4'b0010, 1'b0};
    tv[6] = '{4'b0011, {5'h00, 5'h00, 5'h16, 5'h19}, 4,     1'b0, 3'd0, 5'h19, 4'b0001, 1'b0};

    // Reset then idle for 20 cycles
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("idle_ack",      32'(bus.ack),      32'h0);
      check("idle_dp_start", 32'(bus.dp_start), 32'h0);
      check("idle_busy",     32'(bus.busy),     32'h0);
      check("idle_dp_msg",   32'(bus.dp_msg),   32'h0);
      check("idle_owner",    32'(bus.owner),    32'h0);
      tick();
    end

    // Table of single services, chained through the round-robin pointer
    for (int v = 0; v < 7; v++) begin
      bus.req    = tv[v].req;
      bus.msg_in = tv[v].msg_in;
      tick();
      check("tv_dp_start", 32'(bus.dp_start), 32'h1);
      check("tv_owner",    32'(bus.owner),    32'(tv[v].exp_owner));
      check("tv_dp_msg",   32'(bus.dp_msg),   32'(tv[v].exp_msg));
      check("tv_busy",     32'(bus.busy),     32'h1);
      bus.msg_in = ~tv[v].msg_in;
      if (tv[v].drop) bus.req = '0;
      early = 1'b0;
      if (tv[v].done_dly == NEVER) begin
        repeat (TIMEOUT) begin
          tick();
          if (bus.ack != '0 || bus.dp_start || bus.timeout_err) early = 1'b1;
        end
        tick();
      end else begin
        repeat (tv[v].done_dly) begin
          tick();
          if (bus.ack != '0 || bus.dp_start || bus.timeout_err) early = 1'b1;
        end
        bus.dp_done = 1'b1;
        tick();
        bus.dp_done = 1'b0;
      end
      check("tv_no_early_ack", 32'(early),           32'h0);
      check("tv_ack",          32'(bus.ack),         32'(tv[v].exp_ack));
      check("tv_timeout_err",  32'(bus.timeout_err), 32'(tv[v].exp_terr));
      check("tv_busy_release", 32'(bus.busy),        32'h1);
      check("tv_msg_held",     32'(bus.dp_msg),      32'(tv[v].exp_msg));
      bus.req = '0;
      tick();
      check("tv_ack_width", 32'(bus.ack),         32'h0);
      check("tv_err_width", 32'(bus.timeout_err), 32'h0);
      check("tv_idle_busy", 32'(bus.busy),        32'h0);
      check("tv_owner_hold", 32'(bus.owner),      32'(tv[v].exp_owner));
    end

    // Round-robin with all requests held: order 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req    = 4'b1111;
    bus.msg_in = {5'h04, 5'h03, 5'h02, 5'h01};
    for (int i = 0; i < 5; i++) begin
      exp_o = i % NREQ;
      wait_start(4, seen, ack_seen);
      check("rr_start_seen", 32'(seen),       32'h1);
      check("rr_owner",      32'(bus.owner),  32'(exp_o));
      check("rr_dp_msg",     32'(bus.dp_msg), 32'(exp_o + 1));
      repeat (3) tick();
      bus.dp_done = 1'b1;
      tick();
      bus.dp_done = 1'b0;
      check("rr_ack", 32'(bus.ack), 32'(4'b0001 << exp_o));
      tick();
      check("rr_ack_width", 32'(bus.ack), 32'h0);
    end
    bus.req = '0;
    repeat (3) tick();

    // Reset in the middle of WAIT aborts without ack; held req is regranted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req    = 4'b0010;
    bus.msg_in = {5'h00, 5'h00, 5'h0B, 5'h00};
    tick();
    check("mr_start", 32'(bus.dp_start), 32'h1);
    tick();
    tick();
    check("mr_in_wait", 32'(dbg_state), 32'h2);
    rst = 1'b1;
    tick();
    check("mr_rst_state",    32'(dbg_state),    32'h0);
    check("mr_rst_ack",      32'(bus.ack),      32'h0);
    check("mr_rst_dp_start", 32'(bus.dp_start), 32'h0);
    check("mr_rst_busy",     32'(bus.busy),     32'h0);
    check("mr_rst_owner",    32'(bus.owner),    32'h0);
    rst = 1'b0;
    wait_start(4, seen, ack_seen);
    check("mr_regrant_seen", 32'(seen),       32'h1);
    check("mr_no_ack",       32'(ack_seen),   32'h0);
    check("mr_owner",        32'(bus.owner),  32'h1);
    check("mr_dp_msg",       32'(bus.dp_msg), 32'h0B);
    repeat (2) tick();
    bus.dp_done = 1'b1;
    tick();
    bus.dp_done = 1'b0;
    check("mr_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
